sap1_control_sequencer: RTL and testbench

//   SAP-1 controller-sequencer: the initiator that drives the program counter and all bus agents.
//   - One-hot ring counter steps T1..T6 each clk.
//   - Decodes the IR opcode into the per-T-state control word.
//   - Issues Cp/Ep to the PC, Lm to the MAR, CE to the RAM, Li/Ei to the IR,
//     La/Ea to the A register, Su/Eu to the ALU, Lb to the B register, Lo to the output register.
//   - Halts the machine on HLT.

---
 rtl/sap1_pkg.sv | 51 +++++
 rtl/sap1_control_sequencer_if.sv | 37 +++
 rtl/sap1_ring_counter.sv | 46 ++++
 rtl/sap1_control_sequencer.sv | 117 +++++++++++
 tb/tb_sap1_control_sequencer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/sap1_pkg.sv
// SAP-1 controller-sequencer shared definitions.
// Holds the opcode encodings, the T-state bit indices of the one-hot ring,
// the control-word bit layout and the control-word type. It has no ports.
// The variable machine cycle option is SAP1_EARLY_END_EN; it is consumed by
// sap1_control_sequencer and needs nothing from this package.
package sap1_pkg;

   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned NUM_T    = 6;

   // Instruction encodings (IR upper nibble)
   localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'('h0);
   localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'('h1);
   localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'('h2);
   localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'('hE);
   localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'('hF);

   // Bit index of each T-state in the one-hot ring
   localparam int unsigned T1 = 0;
   localparam int unsigned T2 = 1;
   localparam int unsigned T3 = 2;
   localparam int unsigned T4 = 3;
   localparam int unsigned T5 = 4;
   localparam int unsigned T6 = 5;

   // Control-word bit positions
   localparam int unsigned CW_CP = 0;
   localparam int unsigned CW_EP = 1;
   localparam int unsigned CW_LM = 2;
   localparam int unsigned CW_CE = 3;
   localparam int unsigned CW_LI = 4;
   localparam int unsigned CW_EI = 5;
   localparam int unsigned CW_LA = 6;
   localparam int unsigned CW_EA = 7;
   localparam int unsigned CW_SU = 8;
   localparam int unsigned CW_EU = 9;
   localparam int unsigned CW_LB = 10;
   localparam int unsigned CW_LO = 11;
   localparam int unsigned CW_W  = 12;

   typedef logic [CW_W-1:0]     cw_t;
   typedef logic [NUM_T-1:0]    tstate_t;
   typedef logic [OPCODE_W-1:0] opcode_t;

   // True for opcodes that have an execute phase defined beyond fetch
   function automatic logic is_defined_op(input opcode_t op);
      return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
             (op == OP_OUT) || (op == OP_HLT);
   endfunction

endpackage

// File: rtl/sap1_control_sequencer_if.sv
// SAP-1 control bus between the sequencer and the datapath agents.
// Signals:
//   opcode   IR upper nibble, driven by the datapath, valid T4..T6
//   t_state  one-hot ring state, bit0 = T1
//   cp..lo   per-agent control strobes (PC, MAR, RAM, IR, A, ALU, B, OUT)
//   halt     sticky halt flag
// Modports: master = sequencer, slave = datapath agents.
interface sap1_control_sequencer_if;
   import sap1_pkg::*;

   opcode_t opcode;
   tstate_t t_state;
   logic    cp;
   logic    ep;
   logic    lm;
   logic    ce;
   logic    li;
   logic    ei;
   logic    la;
   logic    ea;
   logic    su;
   logic    eu;
   logic    lb;
   logic    lo;
   logic    halt;

   modport master (
      input  opcode,
      output t_state, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, halt
   );

   modport slave (
      output opcode,
      input  t_state, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, halt
   );

endinterface

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring for the SAP-1 sequencer.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset, returns the ring to T1
//   hold_i     freeze the ring (machine halted)
//   wrap_i     return to T1 on this edge instead of rotating
//   t_state_o  one-hot state, bit0 = T1
// Priority: rst > hold_i > wrap_i > rotate.
module sap1_ring_counter
   import sap1_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    hold_i,
   input  logic    wrap_i,
   output tstate_t t_state_o
);

   localparam tstate_t T1_ONEHOT = NUM_T'(1);

   tstate_t t_state_q;
   tstate_t t_state_d;

   // Next-state selection
   always_comb begin
      t_state_d = t_state_q;
      if (hold_i) begin
         t_state_d = t_state_q;
      end else if (wrap_i) begin
         t_state_d = T1_ONEHOT;
      end else begin
         t_state_d = {t_state_q[NUM_T-2:0], t_state_q[NUM_T-1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         t_state_q <= T1_ONEHOT;
      end else begin
         t_state_q <= t_state_d;
      end
   end

   assign t_state_o = t_state_q;

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 controller-sequencer: steps the T-state ring, decodes the IR opcode
// into the per-T-state control word and halts the machine on HLT.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (T1, halt cleared, controls forced 0)
//   bus   sap1_control_sequencer_if.master: opcode in; t_state, control
//         strobes and halt out
// Control strobes are combinational from t_state, opcode, halt and rst;
// t_state and halt are registered.
// Build option: SAP1_EARLY_END_EN selects a variable machine cycle
// (LDA/NOP end after T5, OUT after T4, ADD/SUB use all six states).
module sap1_control_sequencer
   import sap1_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   sap1_control_sequencer_if.master bus
);

   tstate_t t_state;
   logic    halt_q;
   logic    halt_d;
   logic    early_wrap;
   cw_t     cw_c;

   // Decide whether the current instruction ends before T6
`ifdef SAP1_EARLY_END_EN
   always_comb begin
      early_wrap = 1'b0;
      if (t_state[T4] && (bus.opcode == OP_OUT)) begin
         early_wrap = 1'b1;
      end else if (t_state[T5] &&
                   ((bus.opcode == OP_LDA) || !is_defined_op(bus.opcode))) begin
         early_wrap = 1'b1;
      end
   end
`else
   assign early_wrap = 1'b0;
`endif

   sap1_ring_counter u_ring (
      .clk       (clk),
      .rst       (rst),
      .hold_i    (halt_q),
      .wrap_i    (early_wrap),
      .t_state_o (t_state)
   );

   // Halt latches on the edge that ends T4 of HLT; the ring still steps to T5
   assign halt_d = halt_q | (t_state[T4] && (bus.opcode == OP_HLT));

   always_ff @(posedge clk) begin
      if (rst) begin
         halt_q <= 1'b0;
      end else begin
         halt_q <= halt_d;
      end
   end

   // Control-word decode: fetch is opcode-independent, execute follows opcode
   always_comb begin
      cw_c = '0;
      if (t_state[T1]) begin
         cw_c[CW_EP] = 1'b1;
         cw_c[CW_LM] = 1'b1;
      end else if (t_state[T2]) begin
         cw_c[CW_CP] = 1'b1;
      end else if (t_state[T3]) begin
         cw_c[CW_CE] = 1'b1;
         cw_c[CW_LI] = 1'b1;
      end else if (t_state[T4]) begin
         if ((bus.opcode == OP_LDA) || (bus.opcode == OP_ADD) ||
             (bus.opcode == OP_SUB)) begin
            cw_c[CW_EI] = 1'b1;
            cw_c[CW_LM] = 1'b1;
         end else if (bus.opcode == OP_OUT) begin
            cw_c[CW_EA] = 1'b1;
            cw_c[CW_LO] = 1'b1;
         end
      end else if (t_state[T5]) begin
         if (bus.opcode == OP_LDA) begin
            cw_c[CW_CE] = 1'b1;
            cw_c[CW_LA] = 1'b1;
         end else if ((bus.opcode == OP_ADD) || (bus.opcode == OP_SUB)) begin
            cw_c[CW_CE] = 1'b1;
            cw_c[CW_LB] = 1'b1;
         end
      end else if (t_state[T6]) begin
         if ((bus.opcode == OP_ADD) || (bus.opcode == OP_SUB)) begin
            cw_c[CW_EU] = 1'b1;
            cw_c[CW_LA] = 1'b1;
            cw_c[CW_SU] = (bus.opcode == OP_SUB);
         end
      end

      // Reset and the halted machine silence every strobe
      if (rst || halt_q) begin
         cw_c = '0;
      end
   end

   assign bus.t_state = t_state;
   assign bus.halt    = halt_q;
   assign bus.cp      = cw_c[CW_CP];
   assign bus.ep      = cw_c[CW_EP];
   assign bus.lm      = cw_c[CW_LM];
   assign bus.ce      = cw_c[CW_CE];
   assign bus.li      = cw_c[CW_LI];
   assign bus.ei      = cw_c[CW_EI];
   assign bus.la      = cw_c[CW_LA];
   assign bus.ea      = cw_c[CW_EA];
   assign bus.su      = cw_c[CW_SU];
   assign bus.eu      = cw_c[CW_EU];
   assign bus.lb      = cw_c[CW_LB];
   assign bus.lo      = cw_c[CW_LO];

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Directed bench for sap1_control_sequencer: a per-cycle vector table of
// {rst, opcode, expected t_state, expected strobes, expected halt}, a
// hand-written mid-cycle reset sweep, and per-cycle invariant checks.
module tb_sap1_control_sequencer;

   logic clk;
   logic rst;

   sap1_control_sequencer_if bus ();

   sap1_control_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe packing used by the bench: bit0 cp, 1 ep, 2 lm, 3 ce, 4 li,
   // 5 ei, 6 la, 7 ea, 8 su, 9 eu, 10 lb, 11 lo
   localparam logic [11:0] C_NONE   = 12'h000;
   localparam logic [11:0] C_CP     = 12'h001;
   localparam logic [11:0] C_EPLM   = 12'h006;
   localparam logic [11:0] C_CELI   = 12'h018;
   localparam logic [11:0] C_EILM   = 12'h024;
   localparam logic [11:0] C_CELA   = 12'h048;
   localparam logic [11:0] C_CELB   = 12'h408;
   localparam logic [11:0] C_EULA   = 12'h240;
   localparam logic [11:0] C_SUEULA = 12'h340;
   localparam logic [11:0] C_EALO   = 12'h880;

   localparam logic [5:0] S1 = 6'b000001;
   localparam logic [5:0] S2 = 6'b000010;
   localparam logic [5:0] S3 = 6'b000100;
   localparam logic [5:0] S4 = 6'b001000;
   localparam logic [5:0] S5 = 6'b010000;
   localparam logic [5:0] S6 = 6'b100000;

   typedef struct packed {
      logic        rst;
      logic [3:0]  op;
      logic [5:0]  t;
      logic [11:0] cw;
      logic        halt;
   } vec_t;

   vec_t vecs[$];
   int   n_checks;
   int   n_fail;
   logic inv_en;

   function automatic logic [11:0] strobes();
      return {bus.lo, bus.lb, bus.eu, bus.su, bus.ea, bus.la,
              bus.ei, bus.li, bus.ce, bus.lm, bus.ep, bus.cp};
   endfunction

   task automatic add(input logic r, input logic [3:0] o, input logic [5:0] t,
                      input logic [11:0] c, input logic h);
      vec_t v;
      v.rst  = r;
      v.op   = o;
      v.t    = t;
      v.cw   = c;
      v.halt = h;
      vecs.push_back(v);
   endtask

   task automatic add_fetch(input logic [3:0] o);
      add(1'b0, o, S1, C_EPLM, 1'b0);
      add(1'b0, o, S2, C_CP,   1'b0);
      add(1'b0, o, S3, C_CELI, 1'b0);
   endtask

   task automatic check_row(input int idx, input vec_t v);
      n_checks++;
      if (bus.t_state !== v.t) begin
         n_fail++;
         $display("FAIL vec%0d t_state: got %b, expected %b", idx, bus.t_state, v.t);
      end
      n_checks++;
      if (strobes() !== v.cw) begin
         n_fail++;
         $display("FAIL vec%0d strobes: got %h, expected %h", idx, strobes(), v.cw);
      end
      n_checks++;
      if (bus.halt !== v.halt) begin
         n_fail++;
         $display("FAIL vec%0d halt: got %b, expected %b", idx, bus.halt, v.halt);
      end
   endtask

   // Per-cycle invariants: one-hot ring, single bus driver, cp never with ep
   always @(negedge clk) begin
      if (inv_en) begin
         n_checks++;
         if (!$onehot(bus.t_state)) begin
            n_fail++;
            $display("FAIL onehot: got %b, required exactly one bit set", bus.t_state);
         end
         n_checks++;
         if ((int'(bus.ep) + int'(bus.ce) + int'(bus.ei) + int'(bus.ea) +
              int'(bus.eu)) > 1 || (bus.cp && bus.ep)) begin
            n_fail++;
            $display("FAIL bus_drivers: got %h, required at most one driver and no cp with ep",
                     strobes());
         end
      end
   end

   initial begin
      inv_en     = 1'b0;
      n_checks   = 0;
      n_fail     = 0;
      rst        = 1'b1;
      bus.opcode = 4'h0;

      // Reset held, then LDA
      add(1'b1, 4'h0, S1, C_NONE, 1'b0);
      add(1'b1, 4'h0, S1, C_NONE, 1'b0);
      add_fetch(4'h0);
      add(1'b0, 4'h0, S4, C_EILM, 1'b0);
      add(1'b0, 4'h0, S5, C_CELA, 1'b0);
`ifndef SAP1_EARLY_END_EN
      add(1'b0, 4'h0, S6, C_NONE, 1'b0);
`endif
      // ADD, with HLT on the opcode lines during fetch (must be ignored)
      add_fetch(4'hF);
      add(1'b0, 4'h1, S4, C_EILM, 1'b0);
      add(1'b0, 4'h1, S5, C_CELB, 1'b0);
      add(1'b0, 4'h1, S6, C_EULA, 1'b0);
      // SUB
      add_fetch(4'h2);
      add(1'b0, 4'h2, S4, C_EILM,   1'b0);
      add(1'b0, 4'h2, S5, C_CELB,   1'b0);
      add(1'b0, 4'h2, S6, C_SUEULA, 1'b0);
      // Undefined opcode behaves as NOP
      add_fetch(4'h7);
      add(1'b0, 4'h7, S4, C_NONE, 1'b0);
      add(1'b0, 4'h7, S5, C_NONE, 1'b0);
`ifndef SAP1_EARLY_END_EN
      add(1'b0, 4'h7, S6, C_NONE, 1'b0);
`endif
      // OUT
      add_fetch(4'hE);
      add(1'b0, 4'hE, S4, C_EALO, 1'b0);
`ifndef SAP1_EARLY_END_EN
      add(1'b0, 4'hE, S5, C_NONE, 1'b0);
      add(1'b0, 4'hE, S6, C_NONE, 1'b0);
`endif
      // HLT: freeze at T5 with strobes silenced for 20 clocks
      add_fetch(4'hF);
      add(1'b0, 4'hF, S4, C_NONE, 1'b0);
      for (int i = 0; i < 20; i++) add(1'b0, 4'hF, S5, C_NONE, 1'b1);
      // Reset while halted
      add(1'b1, 4'hF, S5, C_NONE, 1'b1);
      add(1'b0, 4'h1, S1, C_EPLM, 1'b0);
      add(1'b0, 4'h1, S2, C_CP,   1'b0);
      add(1'b0, 4'h1, S3, C_CELI, 1'b0);
      // Reset at T5 of ADD
      add(1'b0, 4'h1, S4, C_EILM, 1'b0);
      add(1'b1, 4'h1, S5, C_NONE, 1'b0);
      add_fetch(4'hF);
      // Reset at T4 of HLT beats the halt
      add(1'b1, 4'hF, S4, C_NONE, 1'b0);
      add(1'b0, 4'h0, S1, C_EPLM, 1'b0);
      add(1'b0, 4'h0, S2, C_CP,   1'b0);

      repeat (2) @(posedge clk);
      inv_en = 1'b1;

      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         rst        = vecs[i].rst;
         bus.opcode = vecs[i].op;
         #3;
         check_row(i, vecs[i]);
      end

      // Mid-cycle reset from every T-state of ADD
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst        = 1'b0;
         bus.opcode = 4'h1;
         repeat (k) @(posedge clk);
         #1;
         n_checks++;
         if (bus.t_state !== 6'(1 << k)) begin
            n_fail++;
            $display("FAIL midreset_pre%0d t_state: got %b, expected %b",
                     k, bus.t_state, 6'(1 << k));
         end
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         n_checks++;
         if (bus.t_state !== S1 || bus.halt !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_post%0d: got t_state %b halt %b, expected %b halt 0",
                     k, bus.t_state, bus.halt, S1);
         end
      end

      @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
